us_ranger: RTL

Ultrasonic ranging controller for an HC-SR04-class sensor. It sits directly downstream of the 50 MHz → 1 MHz clock divider and consumes its 1 MHz square wave as a microsecond time base. On request it issues the trigger pulse, measures the echo pulse width in microseconds, converts it to centimetres and presents the result with a one-cycle valid strobe, a timeout flag and a post-measurement hold-off.

---
 rtl/us_ranger.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/us_ranger.sv
// Ultrasonic ranging controller: issues a trigger pulse, times the echo in microseconds
// using a 1 MHz time base, converts to centimetres and posts the result with a valid strobe.
module us_ranger #(
    parameter int unsigned TRIG_US    = 10,
    parameter int unsigned TIMEOUT_US = 30000,
    parameter int unsigned HOLDOFF_US = 10000,
    parameter int unsigned CM_DIV     = 58
) (
    input  logic        clk_in,
    input  logic        rst_n,
    input  logic        clk_1mhz,
    input  logic        start,
    input  logic        echo,
    output logic        trig,
    output logic        busy,
    output logic [15:0] echo_us,
    output logic [9:0]  distance_cm,
    output logic        valid,
    output logic        timeout
);

    localparam logic [15:0] TrigCnt    = 16'(TRIG_US);
    localparam logic [15:0] TimeoutCnt = 16'(TIMEOUT_US);
    localparam logic [15:0] HoldoffCnt = 16'(HOLDOFF_US);
    localparam logic [15:0] CmDiv      = 16'(CM_DIV);

    typedef enum logic [2:0] {
        StIdle, StTrig, StWaitEcho, StMeasure, StCalc, StDone, StHoldoff
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] rem_q, rem_d;
    logic [9:0]  quo_q, quo_d;
    logic        trig_q, trig_d;
    logic        busy_q, busy_d;
    logic        valid_q, valid_d;
    logic        timeout_q, timeout_d;
    logic [15:0] echo_us_q, echo_us_d;
    logic [9:0]  dist_q, dist_d;
    logic        clk_1mhz_q;
    logic        echo_meta_q, echo_s_q;

    logic        tick;
    logic [15:0] cnt_inc;

    // clk_1mhz is generated in the clk_in domain, so an edge detect is enough
    assign tick    = clk_1mhz & ~clk_1mhz_q;
    assign cnt_inc = cnt_q + 16'd1;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            trig_q      <= 1'b0;
            busy_q      <= 1'b0;
            valid_q     <= 1'b0;
            timeout_q   <= 1'b0;
            echo_us_q   <= '0;
            dist_q      <= '0;
            clk_1mhz_q  <= 1'b0;
            echo_meta_q <= 1'b0;
            echo_s_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            trig_q      <= trig_d;
            busy_q      <= busy_d;
            valid_q     <= valid_d;
            timeout_q   <= timeout_d;
            echo_us_q   <= echo_us_d;
            dist_q      <= dist_d;
            clk_1mhz_q  <= clk_1mhz;
            echo_meta_q <= echo;
            echo_s_q    <= echo_meta_q;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        trig_d    = trig_q;
        busy_d    = busy_q;
        valid_d   = 1'b0;
        timeout_d = timeout_q;
        echo_us_d = echo_us_q;
        dist_d    = dist_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StTrig;
                    trig_d  = 1'b1;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                end
            end
            StTrig: begin
                if (tick) begin
                    if (cnt_inc == TrigCnt) begin
                        trig_d  = 1'b0;
                        cnt_d   = '0;
                        state_d = StWaitEcho;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            StWaitEcho: begin
                if (echo_s_q) begin
                    state_d = StMeasure;
                    cnt_d   = '0;
                end else if (tick) begin
                    if (cnt_inc == TimeoutCnt) begin
                        state_d   = StDone;
                        timeout_d = 1'b1;
                        valid_d   = 1'b1;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            StMeasure: begin
                // Falling edge is tested first so it wins over a coincident timeout
                if (!echo_s_q) begin
                    state_d   = StCalc;
                    echo_us_d = cnt_q;
                    rem_d     = cnt_q;
                    quo_d     = '0;
                end else if (tick) begin
                    if (cnt_inc == TimeoutCnt) begin
                        state_d   = StDone;
                        timeout_d = 1'b1;
                        echo_us_d = TimeoutCnt;
                        valid_d   = 1'b1;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            StCalc: begin
                if (rem_q >= CmDiv) begin
                    rem_d = rem_q - CmDiv;
                    quo_d = quo_q + 10'd1;
                end else begin
                    dist_d    = quo_q;
                    timeout_d = 1'b0;
                    valid_d   = 1'b1;
                    state_d   = StDone;
                end
            end
            StDone: begin
                cnt_d   = '0;
                state_d = StHoldoff;
            end
            StHoldoff: begin
                if (tick) begin
                    if (cnt_inc == HoldoffCnt) begin
                        state_d = StIdle;
                        busy_d  = 1'b0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign trig        = trig_q;
    assign busy        = busy_q;
    assign valid       = valid_q;
    assign timeout     = timeout_q;
    assign echo_us     = echo_us_q;
    assign distance_cm = dist_q;

endmodule
